// File: rtl/dma_tcdm_pkg.sv
// dma_tcdm_pkg
// Shared definitions for the DMA TCDM read adapter: FSM state encoding,
// AXI burst/response codes, the bank word width and the tail fields of an
// R FIFO entry. The id/data fields of the entry depend on top-level
// parameters, so the full entry struct is assembled in the top module.
package dma_tcdm_pkg;

    localparam int unsigned BankDataWidth = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ERR   = 2'd2
    } state_e;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    // Parameter-independent tail of an R FIFO entry.
    typedef struct packed {
        logic [1:0] resp;
        logic       last;
    } r_tail_t;

endpackage

// File: rtl/dma_tcdm_beat_collector.sv
// dma_tcdm_beat_collector
// Gathers the per-bank read responses of one beat. Each bank has a 32-bit
// data register and a valid flag; banks may answer in different cycles.
// Ports: clk_i/rst_ni, rvalid_i/rdata_i bank responses, push_o asserted in
// the cycle the last outstanding bank answers, data_o the assembled beat
// (valid while push_o is high).
module dma_tcdm_beat_collector
    import dma_tcdm_pkg::*;
#(
    parameter int unsigned NumBanks = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumBanks-1:0]               rvalid_i,
    input  logic [NumBanks*BankDataWidth-1:0] rdata_i,
    output logic                              push_o,
    output logic [NumBanks*BankDataWidth-1:0] data_o
);

    logic [NumBanks-1:0]               flags_q;
    logic [NumBanks-1:0]               flags_d;
    logic [NumBanks*BankDataWidth-1:0] data_q;
    logic [NumBanks-1:0]               seen_s;

    // Merge live responses with stored words so the beat can be pushed in
    // the same cycle its last bank answers (no extra cycle of latency).
    always_comb begin
        data_o = data_q;
        for (int unsigned i = 0; i < NumBanks; i++) begin
            data_o[i*BankDataWidth +: BankDataWidth] = rvalid_i[i]
                ? rdata_i[i*BankDataWidth +: BankDataWidth]
                : data_q[i*BankDataWidth +: BankDataWidth];
        end
        seen_s  = flags_q | rvalid_i;
        push_o  = &seen_s;
        flags_d = push_o ? '0 : seen_s;
    end

    // Per-bank data and valid flag registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flags_q <= '0;
            data_q  <= '0;
        end else begin
            flags_q <= flags_d;
            data_q  <= data_o;
        end
    end

endmodule

// File: rtl/fifo_v3.sv
// fifo_v3
// Small synchronous FIFO (common_cells-style interface subset).
// Ports: clk_i/rst_ni clock and async active-low reset, flush_i empties the
// FIFO, push_i/data_i write side, pop_i/data_o read side (data_o is the head
// entry), empty_o head-valid indication. Push while full is accepted only
// together with a pop in the same cycle.
module fifo_v3 #(
    parameter int unsigned DEPTH = 2,
    parameter type         dtype = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    output logic empty_o,
    input  dtype data_i,
    input  logic push_i,
    output dtype data_o,
    input  logic pop_i
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] cnt_q;
    dtype            mem_q [DEPTH];
    logic            push_ok_s;
    logic            pop_ok_s;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : (p + PtrW'(1));
    endfunction

    assign empty_o   = (cnt_q == '0);
    assign pop_ok_s  = pop_i & ~empty_o;
    assign push_ok_s = push_i & ((cnt_q != CntW'(DEPTH)) | pop_ok_s);
    assign data_o    = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok_s) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/dma_tcdm_read_adapter.sv
// dma_tcdm_read_adapter
// Converts AXI4 AR bursts into per-beat TCDM requests striped over NumBanks
// 32-bit bank ports, and reassembles bank responses into in-order R beats.
// Ports: AR channel (ar_*), R channel (r_*), TCDM bank ports (mem_*, one
// req/gnt/rvalid bit and one address/data slice per bank), busy_o.
// WRAP bursts are answered with SLVERR beats without touching memory.
// A credit counter (FIFO entries + in-flight beats) bounds outstanding
// beats to RespFifoDepth, so the response FIFO can never overflow.
module dma_tcdm_read_adapter
    import dma_tcdm_pkg::*;
#(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned AxiDataWidth  = 64,
    parameter int unsigned IdWidth       = 4,
    parameter int unsigned NumBanks      = 2,
    parameter int unsigned RespFifoDepth = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              ar_valid_i,
    output logic                              ar_ready_o,
    input  logic [IdWidth-1:0]                ar_id_i,
    input  logic [AddrWidth-1:0]              ar_addr_i,
    input  logic [7:0]                        ar_len_i,
    input  logic [2:0]                        ar_size_i,
    input  logic [1:0]                        ar_burst_i,
    output logic                              r_valid_o,
    input  logic                              r_ready_i,
    output logic [IdWidth-1:0]                r_id_o,
    output logic [AxiDataWidth-1:0]           r_data_o,
    output logic [1:0]                        r_resp_o,
    output logic                              r_last_o,
    output logic [NumBanks-1:0]               mem_req_o,
    input  logic [NumBanks-1:0]               mem_gnt_i,
    output logic [NumBanks*AddrWidth-1:0]     mem_addr_o,
    output logic [NumBanks-1:0]               mem_we_o,
    input  logic [NumBanks-1:0]               mem_rvalid_i,
    input  logic [NumBanks*BankDataWidth-1:0] mem_rdata_i,
    output logic                              busy_o
);

    localparam int unsigned BeatBytes = AxiDataWidth / 8;
    localparam int unsigned CredW     = $clog2(RespFifoDepth + 1);
    localparam logic [CredW-1:0]     CredMax   = CredW'(RespFifoDepth);
    localparam logic [AddrWidth-1:0] AlignMask = ~AddrWidth'(BeatBytes - 1);

    typedef struct packed {
        logic [IdWidth-1:0]      id;
        logic [AxiDataWidth-1:0] data;
        r_tail_t                 tail;
    } r_entry_t;

    state_e                 state_q, state_d;
    logic                   ar_ready_q, ar_ready_d;
    logic [IdWidth-1:0]     id_q, id_d;
    logic [7:0]             len_q, len_d;
    logic [2:0]             size_q, size_d;
    logic [1:0]             burst_q, burst_d;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic [NumBanks-1:0]    granted_q, granted_d;
    logic                   beat_open_q, beat_open_d;
    logic [CredW-1:0]       cred_q, cred_d;
    logic [IdWidth-1:0]     meta_id_q, meta_id_d;
    logic                   meta_last_q, meta_last_d;

    logic                   can_issue_s;
    logic                   beat_start_s;
    logic                   beat_active_s;
    logic                   beat_done_s;
    logic [NumBanks-1:0]    req_s;
    logic [NumBanks-1:0]    granted_now_s;
    logic                   err_push_s;
    logic                   coll_push_s;
    logic [AxiDataWidth-1:0] coll_data_s;
    logic                   fifo_push_s;
    logic                   fifo_pop_s;
    logic                   fifo_empty_s;
    r_entry_t               push_entry_s;
    r_entry_t               head_entry_s;
    logic [AddrWidth-1:0]   addr_step_s;

    // Beat issue: a beat starts only with a free credit; once started it
    // keeps requesting each bank until that bank is granted.
    always_comb begin
        can_issue_s   = (cred_q < CredMax);
        beat_start_s  = (state_q == ST_ISSUE) & ~beat_open_q & can_issue_s;
        beat_active_s = beat_open_q | beat_start_s;
        req_s         = beat_active_s ? ~granted_q : '0;
        granted_now_s = granted_q | (req_s & mem_gnt_i);
        beat_done_s   = beat_active_s & (&granted_now_s);
        granted_d     = beat_done_s ? '0 : granted_now_s;
        beat_open_d   = beat_active_s & ~beat_done_s;
        // ERR beats yield to a collector push so FIFO order stays intact.
        err_push_s    = (state_q == ST_ERR) & can_issue_s & ~coll_push_s;
        fifo_pop_s    = ~fifo_empty_s & r_ready_i;
        fifo_push_s   = coll_push_s | err_push_s;
        addr_step_s   = (burst_q == BURST_FIXED) ? '0 : (AddrWidth'(1'b1) << size_q);
    end

    // Credit counter tracks FIFO entries plus in-flight beats, net of pops.
    always_comb begin
        case ({(beat_start_s | err_push_s), fifo_pop_s})
            2'b10:   cred_d = cred_q + CredW'(1);
            2'b01:   cred_d = cred_q - CredW'(1);
            default: cred_d = cred_q;
        endcase
    end

    // Entry written to the R FIFO: collected data or an SLVERR filler beat.
    always_comb begin
        if (coll_push_s) begin
            push_entry_s.id        = meta_id_q;
            push_entry_s.data      = coll_data_s;
            push_entry_s.tail.resp = RESP_OKAY;
            push_entry_s.tail.last = meta_last_q;
        end else begin
            push_entry_s.id        = id_q;
            push_entry_s.data      = '0;
            push_entry_s.tail.resp = RESP_SLVERR;
            push_entry_s.tail.last = (len_q == 8'd0);
        end
    end

    // FSM next state and burst bookkeeping.
    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        addr_d      = addr_q;
        meta_id_d   = meta_id_q;
        meta_last_d = meta_last_q;
        case (state_q)
            ST_IDLE: begin
                if (ar_valid_i && ar_ready_q) begin
                    id_d    = ar_id_i;
                    len_d   = ar_len_i;
                    size_d  = ar_size_i;
                    burst_d = ar_burst_i;
                    addr_d  = ar_addr_i & AlignMask;
                    state_d = (ar_burst_i == BURST_WRAP) ? ST_ERR : ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (beat_done_s) begin
                    // Responses of this beat arrive next cycle; tag them now.
                    meta_id_d   = id_q;
                    meta_last_d = (len_q == 8'd0);
                    addr_d      = addr_q + addr_step_s;
                    if (len_q == 8'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        len_d = len_q - 8'd1;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ERR: begin
                if (err_push_s) begin
                    if (len_q == 8'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        len_d = len_q - 8'd1;
                    end
                end else begin
                    state_d = ST_ERR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ar_ready_d = (state_d == ST_IDLE);
    end

    // FSM and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            ar_ready_q  <= 1'b0;
            id_q        <= '0;
            len_q       <= 8'd0;
            size_q      <= 3'd0;
            burst_q     <= 2'd0;
            addr_q      <= '0;
            granted_q   <= '0;
            beat_open_q <= 1'b0;
            cred_q      <= '0;
            meta_id_q   <= '0;
            meta_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ar_ready_q  <= ar_ready_d;
            id_q        <= id_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            addr_q      <= addr_d;
            granted_q   <= granted_d;
            beat_open_q <= beat_open_d;
            cred_q      <= cred_d;
            meta_id_q   <= meta_id_d;
            meta_last_q <= meta_last_d;
        end
    end

    // Bank addresses are driven only while a beat is being requested.
    always_comb begin
        mem_addr_o = '0;
        for (int unsigned i = 0; i < NumBanks; i++) begin
            mem_addr_o[i*AddrWidth +: AddrWidth] = beat_active_s
                ? (addr_q + AddrWidth'(i * 4))
                : '0;
        end
    end

    dma_tcdm_beat_collector #(
        .NumBanks (NumBanks)
    ) i_collector (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .rvalid_i (mem_rvalid_i),
        .rdata_i  (mem_rdata_i),
        .push_o   (coll_push_s),
        .data_o   (coll_data_s)
    );

    fifo_v3 #(
        .DEPTH (RespFifoDepth),
        .dtype (r_entry_t)
    ) i_r_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .empty_o (fifo_empty_s),
        .data_i  (push_entry_s),
        .push_i  (fifo_push_s),
        .data_o  (head_entry_s),
        .pop_i   (fifo_pop_s)
    );

    assign ar_ready_o = ar_ready_q;
    assign mem_req_o  = req_s;
    assign mem_we_o   = '0;
    assign r_valid_o  = ~fifo_empty_s;
    assign r_id_o     = head_entry_s.id;
    assign r_data_o   = head_entry_s.data;
    assign r_resp_o   = head_entry_s.tail.resp;
    assign r_last_o   = head_entry_s.tail.last;
    assign busy_o     = (state_q != ST_IDLE) | (cred_q != '0);

endmodule

// File: tb/tb_dma_tcdm_read_adapter.sv
// Directed bench for dma_tcdm_read_adapter with a simple TCDM bank model:
// grants are gnt_en & mem_req, responses return one cycle after grant with
// data = byte address | 0x5A5A0000 (or 0xA/0xB in fixed_mode).
module tb_dma_tcdm_read_adapter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ar_valid;
    logic        ar_ready;
    logic [3:0]  ar_id;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        r_valid;
    logic        r_ready;
    logic [3:0]  r_id;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic [1:0]  mem_req;
    logic [1:0]  mem_gnt;
    logic [63:0] mem_addr;
    logic [1:0]  mem_we;
    logic [1:0]  mem_rvalid;
    logic [63:0] mem_rdata;
    logic        busy;

    logic [1:0]  gnt_en;
    logic        fixed_mode;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          req_cnt = 0;

    logic [31:0] a0_q[$];
    logic [31:0] a1_q[$];
    logic [63:0] rd_q[$];
    logic        rl_q[$];
    logic [1:0]  rr_q[$];
    logic [3:0]  ri_q[$];

    always #5 clk = ~clk;

    dma_tcdm_read_adapter dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .ar_valid_i   (ar_valid),
        .ar_ready_o   (ar_ready),
        .ar_id_i      (ar_id),
        .ar_addr_i    (ar_addr),
        .ar_len_i     (ar_len),
        .ar_size_i    (ar_size),
        .ar_burst_i   (ar_burst),
        .r_valid_o    (r_valid),
        .r_ready_i    (r_ready),
        .r_id_o       (r_id),
        .r_data_o     (r_data),
        .r_resp_o     (r_resp),
        .r_last_o     (r_last),
        .mem_req_o    (mem_req),
        .mem_gnt_i    (mem_gnt),
        .mem_addr_o   (mem_addr),
        .mem_we_o     (mem_we),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .busy_o       (busy)
    );

    assign mem_gnt = gnt_en & mem_req;

    // Bank model: one-cycle read latency after grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rvalid <= 2'b00;
            mem_rdata  <= 64'd0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                mem_rvalid[b] <= mem_req[b] & mem_gnt[b];
                if (mem_req[b] & mem_gnt[b]) begin
                    if (fixed_mode) begin
                        mem_rdata[b*32 +: 32] <= (b == 0) ? 32'h0000000A : 32'h0000000B;
                    end else begin
                        mem_rdata[b*32 +: 32] <= mem_addr[b*32 +: 32] | 32'h5A5A0000;
                    end
                end
            end
        end
    end

    // Record granted bank addresses and accepted R beats.
    always @(posedge clk) begin
        if (rst_n) begin
            if (mem_req[0] & mem_gnt[0]) a0_q.push_back(mem_addr[31:0]);
            if (mem_req[1] & mem_gnt[1]) a1_q.push_back(mem_addr[63:32]);
            if (|mem_req) req_cnt++;
            if (r_valid & r_ready) begin
                rd_q.push_back(r_data);
                rl_q.push_back(r_last);
                rr_q.push_back(r_resp);
                ri_q.push_back(r_id);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        a0_q.delete();
        a1_q.delete();
        rd_q.delete();
        rl_q.delete();
        rr_q.delete();
        ri_q.delete();
        req_cnt = 0;
    endtask

    task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int guard = 0;
        while (ar_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        chk("ar_ready_wait", ar_ready, 1);
        ar_id    = id;
        ar_addr  = addr;
        ar_len   = len;
        ar_size  = size;
        ar_burst = burst;
        ar_valid = 1'b1;
        tick();
        ar_valid = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int guard = 0;
        while (rd_q.size() < n && guard < budget) begin
            tick();
            guard++;
        end
        chk("beat_count", rd_q.size(), n);
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (busy !== 1'b0 && guard < 40) begin
            tick();
            guard++;
        end
        chk("idle", busy, 0);
    endtask

    initial begin
        rst_n      = 1'b0;
        ar_valid   = 1'b0;
        ar_id      = 4'd0;
        ar_addr    = 32'd0;
        ar_len     = 8'd0;
        ar_size    = 3'd0;
        ar_burst   = 2'd0;
        r_ready    = 1'b0;
        gnt_en     = 2'b11;
        fixed_mode = 1'b0;
        repeat (2) tick();

        // Reset state
        chk("rst_ar_ready", ar_ready, 0);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_ar_ready", ar_ready, 1);

        // Single beat, cycle-exact latency
        fixed_mode = 1'b1;
        do_ar(4'h1, 32'h0000_0100, 8'd0, 3'd3, 2'd1);
        chk("t1_c1_req", mem_req, 2'b11);
        chk("t1_c1_addr", mem_addr, 64'h00000104_00000100);
        chk("t1_c1_busy", busy, 1);
        tick();
        chk("t1_c2_req", mem_req, 2'b00);
        chk("t1_c2_rvalid", r_valid, 0);
        tick();
        chk("t1_c3_rvalid", r_valid, 1);
        chk("t1_c3_data", r_data, 64'h0000000B_0000000A);
        chk("t1_c3_resp", r_resp, 2'd0);
        chk("t1_c3_last", r_last, 1);
        chk("t1_c3_id", r_id, 4'h1);
        r_ready = 1'b1;
        tick();
        chk("t1_c4_rvalid", r_valid, 0);
        chk("t1_c4_busy", busy, 0);
        fixed_mode = 1'b0;

        // 4-beat INCR with R backpressure: credit limit stalls issue at 2
        clear_mon();
        r_ready = 1'b0;
        do_ar(4'h2, 32'h0000_01F8, 8'd3, 3'd3, 2'd1);
        repeat (6) tick();
        chk("t2_stall_beats", a0_q.size(), 2);
        chk("t2_stall_req", mem_req, 2'b00);
        chk("t2_stall_rvalid", r_valid, 1);
        chk("t2_stall_ar_ready", ar_ready, 0);
        r_ready = 1'b1;
        wait_beats(4, 60);
        chk("t2_addr0", a0_q[0], 32'h000001F8);
        chk("t2_addr1", a0_q[1], 32'h00000200);
        chk("t2_addr2", a0_q[2], 32'h00000208);
        chk("t2_addr3", a0_q[3], 32'h00000210);
        chk("t2_bank1_addr3", a1_q[3], 32'h00000214);
        chk("t2_last", {rl_q[3], rl_q[2], rl_q[1], rl_q[0]}, 4'b1000);
        chk("t2_data0", rd_q[0], 64'h5A5A01FC_5A5A01F8);
        chk("t2_data3", rd_q[3], 64'h5A5A0214_5A5A0210);
        chk("t2_id", ri_q[3], 4'h2);
        wait_idle();

        // Skewed grants: bank1 granted three cycles after bank0
        clear_mon();
        gnt_en = 2'b01;
        do_ar(4'h3, 32'h0000_0300, 8'd0, 3'd3, 2'd1);
        chk("t3_c1_req", mem_req, 2'b11);
        tick();
        chk("t3_c2_req", mem_req, 2'b10);
        chk("t3_c2_addr1", mem_addr[63:32], 32'h00000304);
        tick();
        chk("t3_c3_req", mem_req, 2'b10);
        tick();
        gnt_en = 2'b11;
        chk("t3_c4_req", mem_req, 2'b10);
        tick();
        chk("t3_c5_req", mem_req, 2'b00);
        wait_beats(1, 20);
        chk("t3_data", rd_q[0], 64'h5A5A0304_5A5A0300);
        chk("t3_resp", rr_q[0], 2'd0);
        chk("t3_last", rl_q[0], 1);
        wait_idle();

        // WRAP burst: SLVERR beats, no memory access
        clear_mon();
        do_ar(4'h4, 32'h0000_0080, 8'd2, 3'd3, 2'd2);
        wait_beats(3, 40);
        chk("t4_no_req", req_cnt, 0);
        chk("t4_resp", {rr_q[2], rr_q[1], rr_q[0]}, 6'b10_10_10);
        chk("t4_data0", rd_q[0], 64'd0);
        chk("t4_data2", rd_q[2], 64'd0);
        chk("t4_last", {rl_q[2], rl_q[1], rl_q[0]}, 3'b100);
        chk("t4_id", ri_q[1], 4'h4);
        wait_idle();

        // FIXED burst: every beat at the same address
        clear_mon();
        do_ar(4'h5, 32'h0000_0040, 8'd3, 3'd3, 2'd0);
        wait_beats(4, 60);
        for (int i = 0; i < 4; i++) begin
            chk("t5_addr0", a0_q[i], 32'h00000040);
            chk("t5_addr1", a1_q[i], 32'h00000044);
            chk("t5_data", rd_q[i], 64'h5A5A0044_5A5A0040);
        end
        chk("t5_last", {rl_q[3], rl_q[2], rl_q[1], rl_q[0]}, 4'b1000);
        wait_idle();

        // Reset mid-burst
        clear_mon();
        r_ready = 1'b0;
        gnt_en  = 2'b11;
        do_ar(4'h6, 32'h0000_0500, 8'd7, 3'd3, 2'd1);
        tick();
        gnt_en = 2'b00;
        tick();
        chk("t6_pre_req", mem_req, 2'b11);
        chk("t6_pre_rvalid", r_valid, 1);
        chk("t6_pre_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_req", mem_req, 2'b00);
        chk("t6_rst_rvalid", r_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ar_ready", ar_ready, 0);
        tick();
        tick();
        rst_n   = 1'b1;
        gnt_en  = 2'b11;
        r_ready = 1'b1;
        clear_mon();
        do_ar(4'h7, 32'h0000_0604, 8'd0, 3'd3, 2'd1);
        chk("t6_new_addr", mem_addr, 64'h00000604_00000600);
        wait_beats(1, 20);
        chk("t6_new_data", rd_q[0], 64'h5A5A0604_5A5A0600);
        chk("t6_new_id", ri_q[0], 4'h7);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
